// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential RV64M multiply/divide unit:
// op encodings, FSM states, default widths and signedness helpers.
package muldiv_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int CNT_W_DEF = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_MULHSU) || (f3 == F3_DIV) ||
           (f3 == F3_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring
// subtract-and-shift for divide (divide only with MULDIV_DIV_EN).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

`ifdef MULDIV_DIV_EN
  logic [XLEN:0]   x;
  logic [XLEN:0]   y;
  logic            cin;
  logic [XLEN+1:0] s;

  // Shared adder: add multiplicand, or subtract divisor via ~b+1;
  // the top carry is the "no borrow" quotient bit.
  always_comb begin
    x   = {1'b0, hi_i};
    y   = lo_i[0] ? {1'b0, b_i} : '0;
    cin = 1'b0;
    if (div_i) begin
      x   = {hi_i, lo_i[XLEN-1]};
      y   = ~{1'b0, b_i};
      cin = 1'b1;
    end
    s    = {1'b0, x} + {1'b0, y}
         + {{(XLEN+1){1'b0}}, cin};
    hi_o = s[XLEN:1];
    lo_o = {s[0], lo_i[XLEN-1:1]};
    if (div_i) begin
      hi_o = s[XLEN+1] ? s[XLEN-1:0]
                       : x[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], s[XLEN+1]};
    end
  end
`else
  logic [XLEN:0] s;
  logic          unused_div;

  assign unused_div = div_i;
  assign s    = {1'b0, hi_i}
              + (lo_i[0] ? {1'b0, b_i} : '0);
  assign hi_o = s[XLEN:1];
  assign lo_o = {s[0], lo_i[XLEN-1:1]};
`endif

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV64M multiply/divide unit, one bit per cycle.
// Define MULDIV_DIV_EN to include DIV/DIVU/REM/REMU support.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;

  logic              accept, byp;
  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   st_hi, st_lo;
  logic [XLEN-1:0]   fix;
  logic [2*XLEN-1:0] prod, prod_n;
  logic [XLEN-1:0]   mul_sel;

  assign accept = (st_q == S_IDLE) && start && !flush;
  assign sgn_a  = a_signed(funct3) && op_a[XLEN-1];
  assign sgn_b  = b_signed(funct3) && op_b[XLEN-1];

`ifdef MULDIV_DIV_EN
  logic dbz, ovf;
  assign dbz = funct3[2] && (op_b == '0);
  assign ovf = funct3[2] && a_signed(funct3)
            && (op_a == {1'b1, {(XLEN-1){1'b0}}})
            && (&op_b);
  assign byp = dbz || ovf;
`else
  assign byp = funct3[2];
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_i (op_q[2]),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .b_i   (b_q),
    .hi_o  (st_hi),
    .lo_o  (st_lo)
  );

  // Sign-correct the raw magnitudes and pick the requested half.
  always_comb begin
    prod    = {hi_q, lo_q};
    prod_n  = (sa_q ^ sb_q) ? -prod : prod;
    mul_sel = (op_q[1:0] == 2'b00)
            ? prod_n[XLEN-1:0]
            : prod_n[2*XLEN-1:XLEN];
    fix     = '0;
`ifdef MULDIV_DIV_EN
    unique case (1'b1)
      !op_q[2]:
        fix = mul_sel;
      op_q[2] && !op_q[1]:
        fix = (sa_q ^ sb_q) ? -lo_q : lo_q;
      op_q[2] && op_q[1]:
        fix = sa_q ? -hi_q : hi_q;
      default: fix = '0;
    endcase
`else
    fix = op_q[2] ? '0 : mul_sel;
`endif
  end

  // Next state: flush aborts anywhere, special cases skip CALC.
  always_comb begin
    st_d = st_q;
    if (flush) begin
      st_d = S_IDLE;
    end else begin
      case (st_q)
        S_IDLE: if (start)
                  st_d = byp ? S_FIX : S_CALC;
        S_CALC: if (cnt_q == CNT_W'(XLEN-1))
                  st_d = S_FIX;
        S_FIX:  st_d = S_DONE;
        S_DONE: st_d = S_IDLE;
        default: st_d = S_IDLE;
      endcase
    end
  end

  // Datapath: load magnitudes on accept, iterate, capture result.
  always_comb begin
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    op_d  = op_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    res_d = res_q;
    if (accept) begin
      op_d  = funct3;
      sa_d  = sgn_a;
      sb_d  = sgn_b;
      b_d   = sgn_b ? -op_b : op_b;
      hi_d  = '0;
      lo_d  = sgn_a ? -op_a : op_a;
      cnt_d = '0;
`ifdef MULDIV_DIV_EN
      // Preload final values; clearing signs skips correction.
      if (dbz) begin
        sa_d = 1'b0;
        sb_d = 1'b0;
        hi_d = op_a;
        lo_d = '1;
      end else if (ovf) begin
        sa_d = 1'b0;
        sb_d = 1'b0;
        hi_d = '0;
        lo_d = op_a;
      end
`else
      if (funct3[2]) begin
        hi_d = '0;
        lo_d = '0;
      end
`endif
    end else if (!flush && st_q == S_CALC) begin
      hi_d  = st_hi;
      lo_d  = st_lo;
      cnt_d = cnt_q + 1'b1;
    end else if (!flush && st_q == S_FIX) begin
      res_d = fix;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= S_IDLE;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      res_q <= '0;
      op_q  <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      res_q <= res_d;
      op_q  <= op_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
    end
  end

  assign ready  = (st_q == S_IDLE);
  assign busy   = (st_q == S_CALC) || (st_q == S_FIX);
  assign done   = (st_q == S_DONE);
  assign result = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vectors, flush/reset
// sequences and random ops against an arithmetic model.
module tb_muldiv_seq;

  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [63:0] op_a, op_b;
  logic        ready, busy, done;
  logic [63:0] result;

  int nchk = 0;
  int npass = 0;
  logic [63:0] last_exp;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(64), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [63:0] ref_res(
    input logic [2:0] f, input logic [63:0] a,
    input logic [63:0] b);
    logic [127:0] xa, xb, p;
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    xa = a_ext(f, a);
    xb = (f == 3'b000 || f == 3'b001)
       ? {{64{b[63]}}, b} : {64'b0, b};
    p  = xa * xb;
    if (f == 3'b000) return p[63:0];
    if (!f[2]) return p[127:64];
`ifdef MULDIV_DIV_EN
    if (b == 0) return f[1] ? a : ONES;
    if (!f[0]) begin
      if (a == MINV && b == ONES)
        return f[1] ? 64'd0 : a;
      return f[1] ? 64'(sa % sb) : 64'(sa / sb);
    end
    return f[1] ? a % b : a / b;
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [127:0] a_ext(
    input logic [2:0] f, input logic [63:0] a);
    return (f == 3'b011) ? {64'b0, a}
                         : {{64{a[63]}}, a};
  endfunction

  function automatic int ref_lat(
    input logic [2:0] f, input logic [63:0] a,
    input logic [63:0] b);
    if (!f[2]) return 66;
`ifdef MULDIV_DIV_EN
    if (b == 0) return 2;
    if (!f[0] && a == MINV && b == ONES) return 2;
    return 66;
`else
    return 2;
`endif
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic no_done(input string nm, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(nm, 64'(seen), 64'd0);
  endtask

  // Issue one op; optionally poke start with junk mid-CALC.
  task automatic run_op(input string nm, input logic [2:0] f,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] er, input int el,
                        input bit poke);
    int lat;
    lat = 0;
    @(negedge clk);
    chk({nm, " ready"}, 64'(ready), 64'd1);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    funct3 = 3'($urandom);
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (c == 1) chk({nm, " busy"}, 64'(busy), 64'd1);
      if (done) begin
        lat = c;
        break;
      end
      if (poke && c >= 5 && c <= 7) begin
        start = 1'b1; funct3 = 3'b011;
        op_a = 64'd100; op_b = 64'd100;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'(el));
    chk({nm, " result"}, result, er);
    chk({nm, " rdy/busy@done"}, {62'd0, ready, busy}, 64'd0);
    @(negedge clk);
    chk({nm, " after"}, {62'd0, ready, done}, 64'd2);
    chk({nm, " hold"}, result, er);
    last_exp = er;
  endtask

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return ONES;
      2: return MINV;
      3: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0;
    last_exp = '0;

    vecs[0]  = '{3'b000, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 66};
    vecs[1]  = '{3'b011, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66};
    vecs[2]  = '{3'b100, -64'sd7, 64'd2, -64'sd3, 66};
    vecs[3]  = '{3'b110, -64'sd7, 64'd2, ONES, 66};
    vecs[4]  = '{3'b101, 64'd100, 64'd7, 64'd14, 66};
    vecs[5]  = '{3'b100, 64'd5, 64'd0, ONES, 2};
    vecs[6]  = '{3'b110, 64'd5, 64'd0, 64'd5, 2};
    vecs[7]  = '{3'b100, MINV, ONES, MINV, 2};
    vecs[8]  = '{3'b001, ONES, ONES, 64'd0, 66};
    vecs[9]  = '{3'b010, ONES, 64'd2, ONES, 66};
    vecs[10] = '{3'b111, 64'd100, 64'd7, 64'd2, 66};
    vecs[11] = '{3'b110, MINV, ONES, 64'd0, 2};
    vecs[12] = '{3'b101, 64'd5, 64'd0, ONES, 2};
`ifndef MULDIV_DIV_EN
    foreach (vecs[i]) begin
      if (vecs[i].f3[2]) begin
        vecs[i].res = '0;
        vecs[i].lat = 2;
      end
    end
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset flags", {61'd0, ready, busy, done}, 64'd4);
    chk("reset result", result, 64'd0);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a,
             vecs[i].b, vecs[i].res, vecs[i].lat, 1'b0);

    // Flush at CALC cycle 10.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 64'd9; op_b = 64'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush flags", {61'd0, ready, busy, done}, 64'd4);
    no_done("flush no done", 80);
    chk("flush result kept", result, last_exp);

    // Start pulses while busy are dropped, not queued.
    run_op("poke", 3'b000, 64'd3, 64'd5, 64'd15, 66, 1'b1);
    no_done("poke no queue", 80);

    // Start and flush together in IDLE.
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    funct3 = 3'b000; op_a = 64'd2; op_b = 64'd2;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("start+flush flags", {62'd0, ready, busy}, 64'd2);
    no_done("start+flush no done", 80);

    // Reset mid-CALC.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 64'd6; op_b = 64'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst flags", {61'd0, ready, busy, done}, 64'd4);
    chk("midrst result", result, 64'd0);
    no_done("midrst no done", 80);
    run_op("mul3x4", 3'b000, 64'd3, 64'd4, 64'd12, 66, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [63:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = rnd_op();
      b = rnd_op();
      run_op($sformatf("rnd%0d f%0d", i, f), f, a, b,
             ref_res(f, a, b), ref_lat(f, a, b), 1'b0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width.
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width (log2 XLEN).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request valid; accepted only when ready=1.
REQ-006 SHALL have port funct3  input  3  RV64M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port op_a  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-008 SHALL have port op_b  input  XLEN  rs2 operand (multiplier/divisor).
REQ-009 SHALL have port flush  input  1  abort in-flight op (pipeline kill).
REQ-010 SHALL have port ready  output  1  high only in IDLE.
REQ-011 SHALL have port busy  output  1  high in CALC or FIX; drives pipeline stall.
REQ-012 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-013 SHALL have port result  output  XLEN  result; held stable from done until next accept.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 SHALL accept on the edge where start=1, ready=1, flush=0; latch funct3, op_a, op_b; operands and funct3 ignored at all other times.
REQ-016 SHALL, for normal ops, go IDLE->CALC, stay in CALC exactly XLEN cycles (counter 0..XLEN-1, one radix-2 step per cycle), then FIX 1 cycle, then DONE 1 cycle, then IDLE.
REQ-017 SHALL assert done exactly XLEN+2 cycles after the accepting edge (66 at XLEN=64) for normal ops.
REQ-018 SHALL, in CALC, perform shift-add multiply on operand magnitudes, producing a 2*XLEN product; or perform restoring division on magnitudes, producing quotient and remainder.
REQ-019 SHALL take signedness from funct3: MUL/MULH/DIV/REM both signed; MULHSU op_a signed, op_b unsigned; MULHU/DIVU/REMU unsigned.
REQ-020 SHALL, in FIX, apply two's-complement sign correction and select low product half (MUL), high half (MULH*), quotient (DIV*), or remainder (REM*); remainder sign follows dividend.
REQ-021 SHALL, on divide-by-zero, bypass CALC (IDLE->FIX->DONE, done 2 cycles after accept) with quotient all-ones and remainder = op_a.
REQ-022 SHALL, on signed overflow (op_a=-2^(XLEN-1), op_b=-1, DIV/REM), bypass CALC with quotient = op_a and remainder = 0.
REQ-023 SHALL ignore start while not in IDLE; no queueing.
REQ-024 SHALL, on flush=1 in any state, enter IDLE at next edge without asserting done; result keeps its previous value.
REQ-025 SHALL give flush priority over start in the same cycle; request not accepted.
REQ-026 SHALL hold busy=0 and ready=1 in DONE only after the transition to IDLE; in DONE ready=0, busy=0.

Reset
REQ-027 SHALL, on rst=1 at an edge, enter IDLE, clear counter, and set ready=1, busy=0, done=0, result=0.
REQ-028 SHALL give rst priority over flush and start; rst mid-CALC discards the op with no done.

Configuration
REQ-029 SHALL, with MULDIV_DIV_EN defined, implement all eight ops per REQ-016..REQ-022.
REQ-030 SHALL, without MULDIV_DIV_EN, implement multiply only; funct3[2]=1 ops bypass CALC, done 2 cycles after accept, result=0, and no divider logic is synthesized.

Structure
REQ-031 SHALL place funct3 op localparams, the FSM state encoding, and the XLEN default in shared package muldiv_pkg.
REQ-032 SHALL factor the single-iteration add/subtract-and-shift step into combinational sub-module muldiv_step, instantiated once.

Verification
REQ-033 SHALL cover: MUL op_a=7, op_b=-3 -> done at cycle 66, result=-21 (0xFFFF_FFFF_FFFF_FFEB).
REQ-034 SHALL cover: MULHU op_a=op_b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE.
REQ-035 SHALL cover: DIV op_a=-7, op_b=2 -> result=-3; REM same operands -> result=-1; DIVU 100/7 -> 14.
REQ-036 SHALL cover: DIV op_b=0, op_a=5 -> done at cycle 2, result all-ones; REM -> 5; DIV 0x8000_0000_0000_0000 by -1 -> 0x8000_0000_0000_0000.
REQ-037 SHALL cover: flush at CALC cycle 10 -> no done, ready=1 next cycle; start during busy ignored; start+flush same cycle not accepted.
REQ-038 SHALL cover: rst asserted mid-CALC -> next cycle ready=1, busy=0, done=0, result=0; a following MUL 3*4 returns 12.
